// File: rtl/line_sensor_scanner_if.sv
// Serial port of the ADC128S022-style line-sensor ADC. The scanner is the master;
// the ADC (or a bench model of it) is the slave.
interface line_sensor_scanner_if;
  logic cs;    // chip select, active low
  logic sclk;  // serial clock, idles high
  logic din;   // control word into the ADC, changes when sclk falls
  logic dout;  // sample bits out of the ADC, read when sclk rises

  modport master (output cs, output sclk, output din, input dout);
  modport slave  (input cs, input sclk, input din, output dout);
endinterface

// File: rtl/line_sensor_scanner.sv
// Line-sensor scan sequencer: five 16-bit ADC frames per scan, four captured samples,
// thresholded into a 4-bit line pattern and published atomically with a done strobe.
module line_sensor_scanner #(
  parameter logic [11:0] THR      = 12'd500,
  parameter logic [2:0]  CH1      = 3'd0,
  parameter logic [2:0]  CH2      = 3'd1,
  parameter logic [2:0]  CH3      = 3'd2,
  parameter logic [2:0]  CH4      = 3'd3,
  parameter int unsigned AUTO_GAP = 0
) (
  input  logic                  clk_2MHz,
  input  logic                  rst,
  input  logic                  start,
  line_sensor_scanner_if.master adc,
  output logic [11:0]           S1,
  output logic [11:0]           S2,
  output logic [11:0]           S3,
  output logic [11:0]           S4,
  output logic [3:0]            line,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state_o
);
  // Handshake: start is sampled only while IDLE (ignored, never queued, while busy);
  // done is a single-cycle strobe on the cycle S1..S4/line change.
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_SHIFT = 2'd1;
  localparam logic [1:0]  ST_DONE  = 2'd2;
  localparam logic [7:0]  LAST_CNT = 8'd159;
  localparam logic [15:0] GAP      = AUTO_GAP[15:0];
  localparam bit          AUTO     = (AUTO_GAP != 0);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] gap_q, gap_d;
  logic [11:0] sh_q, sh_d;
  logic [11:0] shd_q [4];
  logic [11:0] shd_d [4];
  logic [11:0] s_q [4];
  logic [11:0] s_d [4];
  logic [3:0]  line_q, line_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [11:0] cap;
  logic        go;

  function automatic logic [2:0] frame_addr(input logic [2:0] f);
    case (f)
      3'd1:    frame_addr = CH2;
      3'd2:    frame_addr = CH3;
      3'd3:    frame_addr = CH4;
      default: frame_addr = CH1;
    endcase
  endfunction

  // cnt[7:5] is the frame, cnt[4:1] counts bits from the MSB; address sits in bits 13..11
  function automatic logic ctrl_bit(input logic [7:0] c);
    logic [2:0] a;
    a = frame_addr(c[7:5]);
    case (c[4:1])
      4'd2:    ctrl_bit = a[2];
      4'd3:    ctrl_bit = a[1];
      4'd4:    ctrl_bit = a[0];
      default: ctrl_bit = 1'b0;
    endcase
  endfunction

  assign go  = start || (AUTO && (gap_q == GAP));
  assign cap = {sh_q[10:0], adc.dout};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sh_d    = sh_q;
    shd_d   = shd_q;
    s_d     = s_q;
    line_d  = line_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    din_d   = din_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_SHIFT;
          cnt_d   = 8'd0;
          gap_d   = 16'd0;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          din_d   = ctrl_bit(8'd0);
          busy_d  = 1'b1;
        end else if (AUTO && (gap_q != GAP)) begin
          gap_d = gap_q + 16'd1;
        end
      end
      ST_SHIFT: begin
        // Even counts are the sclk-low half; this edge raises sclk and reads dout.
        if (!cnt_q[0]) begin
          sh_d = cap;
          if (cnt_q[4:1] == 4'd15) begin
            case (cnt_q[7:5])
              3'd1:    shd_d[0] = cap;
              3'd2:    shd_d[1] = cap;
              3'd3:    shd_d[2] = cap;
              3'd4:    shd_d[3] = cap;
              default: ;
            endcase
          end
        end
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          cs_d    = 1'b1;
          sclk_d  = 1'b1;
          done_d  = 1'b1;
          s_d     = shd_q;
          line_d  = {shd_q[0] > THR, shd_q[1] > THR, shd_q[2] > THR, shd_q[3] > THR};
        end else begin
          cnt_d  = cnt_q + 8'd1;
          sclk_d = cnt_d[0];
          if (!cnt_d[0]) din_d = ctrl_bit(cnt_d);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        gap_d   = 16'd0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
        din_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_2MHz) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      gap_q   <= 16'd0;
      sh_q    <= 12'd0;
      shd_q   <= '{default: 12'd0};
      s_q     <= '{default: 12'd0};
      line_q  <= 4'b0000;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      sh_q    <= sh_d;
      shd_q   <= shd_d;
      s_q     <= s_d;
      line_q  <= line_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign adc.cs   = cs_q;
  assign adc.sclk = sclk_q;
  assign adc.din  = din_q;
  assign S1       = s_q[0];
  assign S2       = s_q[1];
  assign S3       = s_q[2];
  assign S4       = s_q[3];
  assign line     = line_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign state_o  = state_q;
endmodule

// File: tb/tb_line_sensor_scanner.sv
// Bench for line_sensor_scanner: a manual-start instance and an AUTO_GAP=10 instance,
// each talking to a behavioural ADC with a one-frame address pipeline.
`timescale 1ns/1ps
module tb_line_sensor_scanner;
  localparam logic [11:0] THR     = 12'd500;
  localparam int          GAP     = 10;
  localparam int          LAT     = 161;
  localparam int          PERIOD  = 162 + GAP;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_DONE = 2'd2;
  localparam logic [2:0]  EXP_ADDR [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_a, start, start_a;
  logic [11:0] s1, s2, s3, s4, a1, a2, a3, a4;
  logic [3:0]  line0, line1;
  logic        busy0, done0, busy1, done1;
  logic [1:0]  st0, st1;

  line_sensor_scanner_if bus0 ();
  line_sensor_scanner_if bus1 ();

  line_sensor_scanner #(.AUTO_GAP(0)) dut (
    .clk_2MHz(clk), .rst(rst), .start(start), .adc(bus0),
    .S1(s1), .S2(s2), .S3(s3), .S4(s4), .line(line0),
    .busy(busy0), .done(done0), .state_o(st0)
  );

  line_sensor_scanner #(.AUTO_GAP(GAP)) dut_auto (
    .clk_2MHz(clk), .rst(rst_a), .start(start_a), .adc(bus1),
    .S1(a1), .S2(a2), .S3(a3), .S4(a4), .line(line1),
    .busy(busy1), .done(done1), .state_o(st1)
  );

  // behavioural ADC: address latched at the end of a frame selects the next frame's data
  logic        cs_w [2];
  logic        sclk_w [2];
  logic        din_w [2];
  logic        dout_r [2];
  logic        prev_sclk [2];
  int          bitk [2];
  logic [15:0] rx [2];
  logic [2:0]  cur_ch [2];
  logic [15:0] word_v;
  logic [11:0] adc_val [2][8];
  logic [2:0]  addr_log [64];
  int          addr_n  = 0;
  int          rsv_bad = 0;

  assign cs_w[0]   = bus0.cs;
  assign sclk_w[0] = bus0.sclk;
  assign din_w[0]  = bus0.din;
  assign cs_w[1]   = bus1.cs;
  assign sclk_w[1] = bus1.sclk;
  assign din_w[1]  = bus1.din;
  assign bus0.dout = dout_r[0];
  assign bus1.dout = dout_r[1];

  initial begin : adc_model
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (cs_w[g] !== 1'b0) begin
          bitk[g]   = 0;
          cur_ch[g] = 3'd0;
          rx[g]     = 16'd0;
          dout_r[g] = 1'b0;
        end else begin
          if (prev_sclk[g] === 1'b1 && sclk_w[g] === 1'b0) begin
            word_v    = {4'b0000, adc_val[g][cur_ch[g]]};
            dout_r[g] = word_v[15 - (bitk[g] % 16)];
          end
          if (prev_sclk[g] === 1'b0 && sclk_w[g] === 1'b1) begin
            rx[g] = {rx[g][14:0], din_w[g]};
            bitk[g]++;
            if (bitk[g] % 16 == 0) begin
              cur_ch[g] = rx[g][13:11];
              if (g == 0) begin
                addr_log[addr_n % 64] = rx[g][13:11];
                addr_n++;
                if ((rx[g] & 16'hC7FF) != 16'd0) rsv_bad++;
              end
            end
          end
        end
        prev_sclk[g] = sclk_w[g];
      end
    end
  end

  // S*/line may only move on a done cycle or right after a reset
  int          hold_bad0 = 0, hold_bad1 = 0;
  logic [51:0] prev0, prev1;
  logic        rpe0, rpe1;
  initial begin : hold_mon
    prev0 = 'x;
    prev1 = 'x;
    forever begin
      @(posedge clk);
      rpe0 = rst;
      rpe1 = rst_a;
      @(negedge clk);
      if (!done0 && !rpe0 && {s1, s2, s3, s4, line0} !== prev0) hold_bad0++;
      if (!done1 && !rpe1 && {a1, a2, a3, a4, line1} !== prev1) hold_bad1++;
      prev0 = {s1, s2, s3, s4, line0};
      prev1 = {a1, a2, a3, a4, line1};
    end
  end

  // scoreboard
  logic [51:0] exp_q[$];
  logic [51:0] exp_q1[$];
  int          n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_line(input logic [11:0] a, b, c, d);
    return {a > THR, b > THR, c > THR, d > THR};
  endfunction

  function automatic logic [11:0] rnd_sample();
    case ($urandom_range(0, 3))
      0:       return THR;
      1:       return THR + 12'd1;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic load(input int g, input logic [11:0] a, b, c, d, input bit push);
    adc_val[g][0] = a;
    adc_val[g][1] = b;
    adc_val[g][2] = c;
    adc_val[g][3] = d;
    if (push && g == 0) exp_q.push_back({a, b, c, d, exp_line(a, b, c, d)});
    if (push && g == 1) exp_q1.push_back({a, b, c, d, exp_line(a, b, c, d)});
  endtask

  task automatic load_rnd(input int g, input bit push);
    load(g, rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), push);
  endtask

  // one manual scan on dut: start sampled at E0, returns in cycle 162 (IDLE)
  task automatic scan_run(input string tag, input int p1, input int p2);
    logic [51:0] old, exp;
    int lat, ndone, bad, a0;
    old   = {s1, s2, s3, s4, line0};
    exp   = exp_q.pop_front();
    a0    = addr_n;
    lat   = 0;
    ndone = 0;
    bad   = 0;
    start = 1'b1;
    for (int k = 1; k <= 162; k++) begin
      step(1);
      start = (k == p1 || k == p2);
      if (done0 === 1'b1) begin
        ndone++;
        if (lat == 0) lat = k;
      end
      if (k <= 160) begin
        if (bus0.cs !== 1'b0 || busy0 !== 1'b1 || bus0.sclk !== (k % 2 == 0) ||
            {s1, s2, s3, s4, line0} !== old) bad++;
      end else if (k == 161) begin
        if (bus0.cs !== 1'b1 || busy0 !== 1'b1 || bus0.sclk !== 1'b1) bad++;
        check({tag, "_result"}, {s1, s2, s3, s4, line0}, exp);
      end else begin
        if (busy0 !== 1'b0 || bus0.cs !== 1'b1 || done0 !== 1'b0) bad++;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_ndone"}, ndone, 1);
    check({tag, "_pins"}, bad, 0);
    check({tag, "_nframes"}, addr_n - a0, 5);
    for (int i = 0; i < 5; i++) check({tag, "_addr"}, addr_log[(a0 + i) % 64], EXP_ADDR[i]);
  endtask

  task automatic idle_watch(input string tag, input int n);
    int nd, nb;
    nd = 0;
    nb = 0;
    for (int k = 0; k < n; k++) begin
      step(1);
      if (done0 !== 1'b0) nd++;
      if (busy0 !== 1'b0 || bus0.cs !== 1'b1 || bus0.sclk !== 1'b1) nb++;
    end
    check({tag, "_done"}, nd, 0);
    check({tag, "_busy"}, nb, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_S"}, {s1, s2, s3, s4, line0}, 52'd0);
    check({tag, "_cs"}, bus0.cs, 1'b1);
    check({tag, "_sclk"}, bus0.sclk, 1'b1);
    check({tag, "_din"}, bus0.din, 1'b0);
    check({tag, "_busy"}, busy0, 1'b0);
    check({tag, "_done"}, done0, 1'b0);
    check({tag, "_state"}, st0, ST_IDLE);
  endtask

  initial begin : main
    int nd;
    rst     = 1'b1;
    rst_a   = 1'b1;
    start   = 1'b0;
    start_a = 1'b0;
    for (int g = 0; g < 2; g++)
      for (int c = 0; c < 8; c++) adc_val[g][c] = 12'hFFF;

    step(3);
    check_reset_outputs("in_reset");
    rst = 1'b0;
    idle_watch("idle", 20);
    check_reset_outputs("idle");

    load(0, 12'd100, 12'd800, 12'd900, 12'd200, 1'b1);
    scan_run("single", 0, 0);

    load(0, 12'd500, 12'd501, 12'd4095, 12'd0, 1'b1);
    scan_run("thr", 0, 0);

    load_rnd(0, 1'b1);
    scan_run("busy_rej", 50, 161);
    idle_watch("no_second", 200);

    for (int i = 0; i < 4; i++) begin
      load_rnd(0, 1'b1);
      scan_run("rand", 0, 0);
    end

    // abort at cycle 90 of a scan that follows a completed one
    load_rnd(0, 1'b0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(89);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_reset_outputs("abort");
    idle_watch("abort_idle", 100);
    load_rnd(0, 1'b1);
    scan_run("post_abort", 0, 0);

    // auto mode
    rst_a = 1'b0;
    step(2);
    load_rnd(1, 1'b1);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    nd = 0;
    for (int k = 1; k <= 1000 && nd < 4; k++) begin
      if (done1 === 1'b1) begin
        nd++;
        check("auto_time", k, LAT + PERIOD * (nd - 1));
        check("auto_result", {a1, a2, a3, a4, line1}, exp_q1.pop_front());
        check("auto_state", st1, ST_DONE);
        if (nd < 4) load_rnd(1, 1'b1);
      end
      if (nd < 4) step(1);
    end
    check("auto_count", nd, 4);

    step(2);
    check("hold_manual", hold_bad0, 0);
    check("hold_auto", hold_bad1, 0);
    check("ctrl_reserved", rsv_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
